// File: rtl/v_issue_ctrl.sv
// Scalar-side issue controller: buffers decoded vector instructions in an in-order FIFO
// and hands them one at a time to the vector unit, with flush and watchdog recovery.
module v_issue_ctrl #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           dec_valid,
    output logic           dec_ready,
    input  logic [108:0]   dec_instr,
    input  logic           flush,
    output logic [108:0]   v_instr,
    output logic           I_start,
    output logic [2:0]     I_id,
    output logic           I_clear,
    input  logic           stall,
    input  logic           DONE,
    output logic           v_busy,
    output logic           err
);

    // state | meaning
    // IDLE  | nothing outstanding, waiting for the FIFO to become non-empty
    // ISSUE | FIFO head presented with I_start, held while stall is high
    // WAIT  | instruction outstanding, watchdog running until DONE
    // CLEAR | one-cycle I_clear pulse after flush or watchdog expiry

    localparam int IW = 109;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;

    logic [IW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [TW-1:0]   wd_cnt;
    logic [2:0]      id_cnt;

    logic            empty;
    logic            full;
    logic            push;
    logic            pop;
    logic            wipe;
    logic            wd_expire;

    assign empty     = (count == '0);
    assign full      = (count == CW'(DEPTH));

    // Reset gates dec_ready so nothing is captured during the reset cycle itself.
    assign dec_ready = !reset && !full && (state != CLEAR) && !flush;
    assign push      = dec_valid && dec_ready;
    assign pop       = (state == ISSUE) && !stall && !flush;

    // DONE in the expiry cycle takes priority, so expiry requires its absence.
    assign wd_expire = (state == WAIT) && !DONE && (wd_cnt == TW'(TIMEOUT - 1));

    // Empty the FIFO on the edge that enters CLEAR so the CLEAR cycle already reads idle.
    assign wipe      = (state_nx == CLEAR);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (!empty) state_nx = ISSUE;
            end
            ISSUE: begin
                if (!stall) state_nx = WAIT;
            end
            WAIT: begin
                if (DONE)           state_nx = empty ? IDLE : ISSUE;
                else if (wd_expire) state_nx = CLEAR;
            end
            CLEAR: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (flush && (state != CLEAR)) state_nx = CLEAR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            wd_cnt <= '0;
            id_cnt <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_nx;

            if (wipe) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end

            if (pop) id_cnt <= id_cnt + 3'd1;

            if (pop)                 wd_cnt <= '0;
            else if (state == WAIT)  wd_cnt <= wd_cnt + TW'(1);

            if (wd_expire) err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec_instr;
    end

    assign I_start = (state == ISSUE);
    assign I_clear = (state == CLEAR);
    assign I_id    = id_cnt;
    assign v_instr = (state == ISSUE) ? mem[rd_ptr] : '0;
    assign v_busy  = !empty || (state == ISSUE) || (state == WAIT);

endmodule
